// File: rtl/pc_target_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : pc_target_unit                                             |
// | Description : Program counter owner with next-PC target computation      |
// |               (SEQ / JMP / BRR / JMPC) over cmd and tgt valid/ready.     |
// | Option      : PC_TARGET_WRAP_CHK_EN adds wrap_err and suppresses         |
// |               boundary-crossing relative branches.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_target_unit #(
   parameter int unsigned          PC_W     = 16,
   parameter int unsigned          IMM_W    = 12,
   parameter int unsigned          SHIFT    = 1,
   parameter int unsigned          INC      = 2,
   parameter logic [PC_W-1:0]      RESET_PC = '0
) (
   input  logic                    CLK,
   input  logic                    Reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_mode,
   input  logic [IMM_W-1:0]        cmd_imm,
   input  logic                    cmd_cond,
   output logic [PC_W-1:0]         pc,
   output logic                    tgt_valid,
   input  logic                    tgt_ready,
   output logic [PC_W-1:0]         tgt_pc,
   output logic                    taken,
`ifdef PC_TARGET_WRAP_CHK_EN
   output logic                    wrap_err,
`endif
   output logic [PC_W-1:0]         ret_pc
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0]      c_mode_seq  = 2'b00;
   localparam logic [1:0]      c_mode_jmp  = 2'b01;
   localparam logic [1:0]      c_mode_brr  = 2'b10;
   localparam logic [1:0]      c_mode_jmpc = 2'b11;
   localparam logic [PC_W-1:0] c_inc       = PC_W'(INC);
   localparam logic [PC_W-1:0] c_ones      = '1;
   // Bits replaced by a JMP target; all ones when the immediate spans the PC.
   localparam logic [PC_W-1:0] c_low_mask  = ~(c_ones << (IMM_W + SHIFT));

   state_t              r_state;
   logic [1:0]          r_mode;
   logic [IMM_W-1:0]    r_imm;
   logic                r_cond;
   logic [PC_W-1:0]     r_pc;
   logic [PC_W-1:0]     r_tgt_pc;
   logic [PC_W-1:0]     r_ret_pc;
   logic                r_taken;
   logic                r_tgt_valid;
   logic                r_cmd_ready;

   logic [PC_W-1:0]     w_pc_inc;
   logic [PC_W-1:0]     w_imm_z;
   logic [PC_W-1:0]     w_imm_sx;
   logic [PC_W-1:0]     w_jmp;
   logic [PC_W-1:0]     w_brr;
   logic [PC_W-1:0]     w_nxt_pc;
   logic                w_nxt_taken;

   // pc is frozen from acceptance until the handshake, so r_pc is the captured pc.
   assign w_pc_inc = r_pc + c_inc;
   assign w_imm_z  = PC_W'(r_imm) << SHIFT;
   assign w_imm_sx = PC_W'($signed(r_imm)) << SHIFT;
   assign w_jmp    = (r_pc & ~c_low_mask) | w_imm_z;

`ifdef PC_TARGET_WRAP_CHK_EN
   logic [PC_W:0]       w_brr_ext;
   logic                w_brr_wrap;
   logic                w_nxt_wrap;
   logic                r_wrap_err;

   // Carry set on a forward offset, or clear on a backward one, means the 0 boundary was crossed.
   assign w_brr_ext  = {1'b0, r_pc} + {1'b0, w_imm_sx};
   assign w_brr      = w_brr_ext[PC_W-1:0];
   assign w_brr_wrap = w_imm_sx[PC_W-1] ? ~w_brr_ext[PC_W] : w_brr_ext[PC_W];
   assign wrap_err   = r_wrap_err;
`else
   assign w_brr      = r_pc + w_imm_sx;
`endif

   always_comb begin
      w_nxt_pc    = w_pc_inc;
      w_nxt_taken = 1'b0;
`ifdef PC_TARGET_WRAP_CHK_EN
      w_nxt_wrap  = 1'b0;
`endif
      case (r_mode)
         c_mode_seq: begin
            w_nxt_pc    = w_pc_inc;
         end
         c_mode_jmp: begin
            w_nxt_pc    = w_jmp;
            w_nxt_taken = 1'b1;
         end
         c_mode_brr: begin
            if (r_cond) begin
`ifdef PC_TARGET_WRAP_CHK_EN
               if (w_brr_wrap) begin
                  w_nxt_wrap  = 1'b1;
               end else begin
                  w_nxt_pc    = w_brr;
                  w_nxt_taken = 1'b1;
               end
`else
               w_nxt_pc    = w_brr;
               w_nxt_taken = 1'b1;
`endif
            end
         end
         c_mode_jmpc: begin
            if (r_cond) begin
               w_nxt_pc    = w_jmp;
               w_nxt_taken = 1'b1;
            end
         end
         default: begin
            w_nxt_pc    = w_pc_inc;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= S_IDLE;
         r_mode      <= c_mode_seq;
         r_imm       <= '0;
         r_cond      <= 1'b0;
         r_pc        <= RESET_PC;
         r_tgt_pc    <= '0;
         r_ret_pc    <= '0;
         r_taken     <= 1'b0;
         r_tgt_valid <= 1'b0;
         r_cmd_ready <= 1'b1;
`ifdef PC_TARGET_WRAP_CHK_EN
         r_wrap_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_mode      <= cmd_mode;
                  r_imm       <= cmd_imm;
                  r_cond      <= cmd_cond;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_CALC;
               end
            end
            S_CALC: begin
               r_tgt_pc    <= w_nxt_pc;
               r_taken     <= w_nxt_taken;
               r_ret_pc    <= w_pc_inc;
               r_tgt_valid <= 1'b1;
`ifdef PC_TARGET_WRAP_CHK_EN
               r_wrap_err  <= w_nxt_wrap;
`endif
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (tgt_ready) begin
                  r_pc        <= r_tgt_pc;
                  r_tgt_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_tgt_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign pc        = r_pc;
   assign tgt_valid = r_tgt_valid;
   assign tgt_pc    = r_tgt_pc;
   assign taken     = r_taken;
   assign ret_pc    = r_ret_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_target_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_pc_target_unit                                          |
// | Description : Directed self-checking bench for pc_target_unit.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_target_unit;

   localparam logic [1:0] c_seq  = 2'b00;
   localparam logic [1:0] c_jmp  = 2'b01;
   localparam logic [1:0] c_brr  = 2'b10;
   localparam logic [1:0] c_jmpc = 2'b11;

   logic        CLK = 1'b0;
   logic        Reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [11:0] cmd_imm;
   logic        cmd_cond;
   logic [15:0] pc;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [15:0] tgt_pc;
   logic        taken;
   logic [15:0] ret_pc;
`ifdef PC_TARGET_WRAP_CHK_EN
   logic        wrap_err;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;

   pc_target_unit u_dut (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_imm   (cmd_imm),
      .cmd_cond  (cmd_cond),
      .pc        (pc),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_pc    (tgt_pc),
      .taken     (taken),
`ifdef PC_TARGET_WRAP_CHK_EN
      .wrap_err  (wrap_err),
`endif
      .ret_pc    (ret_pc)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Present one command, then confirm it sits one cycle in CALC and is valid the next.
   task automatic run_cmd(input logic [1:0] mode, input logic [11:0] imm, input logic cond);
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_imm   = imm;
      cmd_cond  = cond;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      chk("calc_tgt_valid", tgt_valid, 0);
      chk("calc_cmd_ready", cmd_ready, 0);
      @(posedge CLK); #1;
      chk("done_tgt_valid", tgt_valid, 1);
   endtask

   task automatic accept_tgt(input logic [15:0] exp_pc);
      @(negedge CLK);
      tgt_ready = 1'b1;
      @(posedge CLK); #1;
      tgt_ready = 1'b0;
      chk("hs_tgt_valid", tgt_valid, 0);
      chk("hs_cmd_ready", cmd_ready, 1);
      chk("hs_pc", pc, exp_pc);
   endtask

   task automatic check_res(input string tag, input logic [15:0] e_tgt, input logic e_taken,
                            input logic [15:0] e_ret);
      chk({tag, "_tgt_pc"}, tgt_pc, e_tgt);
      chk({tag, "_taken"},  taken,  e_taken);
      chk({tag, "_ret_pc"}, ret_pc, e_ret);
   endtask

   initial begin
      logic seen;
      Reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_mode  = 2'b00;
      cmd_imm   = '0;
      cmd_cond  = 1'b0;
      tgt_ready = 1'b0;
      #12;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_tgt_valid", tgt_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_tgt_pc", tgt_pc, 16'h0000);
      chk("rst_taken", taken, 0);
      chk("rst_ret_pc", ret_pc, 16'h0000);
      @(negedge CLK);
      Reset_n = 1'b1;

      // Absolute jump from 0
      run_cmd(c_jmp, 12'h123, 1'b0);
      check_res("jmp", 16'h0246, 1'b1, 16'h0002);
      accept_tgt(16'h0246);

      // Reach 0x0100, then relative branch backwards
      run_cmd(c_jmp, 12'h080, 1'b0);
      accept_tgt(16'h0100);
      run_cmd(c_brr, 12'hFFE, 1'b1);
      check_res("brr_t", 16'h00FC, 1'b1, 16'h0102);
      accept_tgt(16'h00FC);
      run_cmd(c_jmp, 12'h080, 1'b0);
      accept_tgt(16'h0100);
      run_cmd(c_brr, 12'hFFE, 1'b0);
      check_res("brr_nt", 16'h0102, 1'b0, 16'h0102);
      accept_tgt(16'h0102);

      // Back-pressure in DONE with a stray command offered
      run_cmd(c_seq, 12'h000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         cmd_valid = (i == 1);
         cmd_mode  = c_jmp;
         cmd_imm   = 12'hFFF;
         cmd_cond  = 1'b1;
         @(posedge CLK); #1;
         chk("stall_tgt_pc", tgt_pc, 16'h0104);
         chk("stall_taken", taken, 0);
         chk("stall_cmd_ready", cmd_ready, 0);
         chk("stall_pc", pc, 16'h0102);
         chk("stall_tgt_valid", tgt_valid, 1);
      end
      cmd_valid = 1'b0;
      accept_tgt(16'h0104);
      @(posedge CLK); #1;
      chk("stray_ignored", tgt_valid, 0);

      // Conditional absolute jump
      run_cmd(c_jmpc, 12'h010, 1'b0);
      check_res("jmpc_nt", 16'h0106, 1'b0, 16'h0106);
      accept_tgt(16'h0106);
      run_cmd(c_jmpc, 12'h010, 1'b1);
      check_res("jmpc_t", 16'h0020, 1'b1, 16'h0108);
      accept_tgt(16'h0020);

      // Asynchronous reset while a result waits in DONE
      run_cmd(c_jmp, 12'h0FF, 1'b0);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_pc", pc, 16'h0000);
      chk("arst_tgt_valid", tgt_valid, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_taken", taken, 0);
      @(negedge CLK);
      Reset_n = 1'b1;

      // Branch across zero
      run_cmd(c_seq, 12'h000, 1'b0);
      accept_tgt(16'h0002);
      run_cmd(c_brr, 12'hFFC, 1'b1);
`ifdef PC_TARGET_WRAP_CHK_EN
      check_res("wrapchk", 16'h0004, 1'b0, 16'h0004);
      chk("wrapchk_err", wrap_err, 1);
      accept_tgt(16'h0004);
`else
      check_res("brr_wrap", 16'hFFFA, 1'b1, 16'h0004);
      accept_tgt(16'hFFFA);
      run_cmd(c_jmp, 12'hFFF, 1'b0);
      check_res("jmp_hi", 16'hFFFE, 1'b1, 16'hFFFC);
      accept_tgt(16'hFFFE);
      run_cmd(c_seq, 12'h000, 1'b0);
      check_res("seq_wrap", 16'h0000, 1'b0, 16'h0000);
      accept_tgt(16'h0000);
`endif

      // Reset pulsed while in CALC
      run_cmd(c_jmp, 12'h123, 1'b0);
      accept_tgt(16'h0246);
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_mode  = c_seq;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      chk("calc_entry", cmd_ready, 0);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("crst_pc", pc, 16'h0000);
      chk("crst_cmd_ready", cmd_ready, 1);
      chk("crst_tgt_valid", tgt_valid, 0);
      @(negedge CLK);
      Reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         if (tgt_valid) seen = 1'b1;
      end
      chk("crst_no_valid", seen, 0);
      chk("crst_pc_hold", pc, 16'h0000);

      // Normal operation resumes
      run_cmd(c_seq, 12'h000, 1'b0);
      check_res("post_rst", 16'h0002, 1'b0, 16'h0002);
      accept_tgt(16'h0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
